// File: rtl/axi_pkg.sv
// Shared AXI4 read-side definitions: burst/size/resp codes, AR request bundle, arbiter states.
// Field widths match the default 32-bit address / 4-bit ID configuration.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_RDATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the port that did not win last time is chosen.
// Latency: combinational, zero cycles.
// Backpressure: none; grant_oh is one-hot or zero and follows req directly.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant_oh
);

    always_comb begin
        grant_oh = req;
        if (&req) begin
            grant_oh = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master (AR+R) between icache refill (port 0) and LSU loads (port 1).
// Latency: requester AR handshake in cycle N gives M_AXI_ARVALID in N+1; R beats pass through combinationally.
// Backpressure: one transaction outstanding; s_arready is held low until the burst's RLAST handshake completes.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clock,
    input  logic                    rst_n_sync,
    input  logic [2*ADDR_WIDTH-1:0] s_araddr,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    input  logic [2*ID_WIDTH-1:0]   s_arid,
    input  logic [15:0]             s_arlen,
    input  logic [5:0]              s_arsize,
    input  logic [3:0]              s_arburst,
    output logic [2*DATA_WIDTH-1:0] s_rdata,
    output logic [3:0]              s_rresp,
    output logic [1:0]              s_rvalid,
    output logic [1:0]              s_rlast,
    input  logic [1:0]              s_rready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    output logic [ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [7:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    input  logic                    M_AXI_RLAST,
    input  logic [ID_WIDTH-1:0]     M_AXI_RID,
    output logic                    M_AXI_RREADY,
    output logic                    busy,
    output logic                    proto_err
);

    rd_state_t state;
    ar_req_t   req_q;
    ar_req_t   win_req;
    logic      grant;
    logic      last_grant;
    logic [8:0] beat_cnt;
    logic      arvalid_q;
    logic      proto_err_q;
    logic [1:0] grant_oh;
    logic      win;
    logic      in_idle;
    logic      in_rdata;
    logic      r_beat;
    logic      unused_rid;

    rr_arb2 u_rr_arb2 (
        .req        (s_arvalid),
        .last_grant (last_grant),
        .grant_oh   (grant_oh)
    );

    assign win = grant_oh[1];

    always_comb begin
        win_req.addr  = win ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
        win_req.id    = win ? s_arid[2*ID_WIDTH-1:ID_WIDTH]       : s_arid[ID_WIDTH-1:0];
        win_req.len   = win ? s_arlen[15:8]   : s_arlen[7:0];
        win_req.size  = win ? s_arsize[5:3]   : s_arsize[2:0];
        win_req.burst = win ? s_arburst[3:2]  : s_arburst[1:0];
    end

    // Qualify with reset so nothing handshakes in a cycle that is about to be discarded.
    assign in_idle  = (state == ST_IDLE)  && rst_n_sync;
    assign in_rdata = (state == ST_RDATA) && rst_n_sync;
    assign r_beat   = in_rdata && M_AXI_RVALID && s_rready[grant];

    assign s_arready    = in_idle ? grant_oh : 2'b00;
    assign M_AXI_RREADY = in_rdata && s_rready[grant];
    assign s_rvalid     = in_rdata ? (grant ? {M_AXI_RVALID, 1'b0} : {1'b0, M_AXI_RVALID}) : 2'b00;
    assign s_rlast      = in_rdata ? (grant ? {M_AXI_RLAST, 1'b0}  : {1'b0, M_AXI_RLAST})  : 2'b00;
    assign s_rdata      = {2{M_AXI_RDATA}};
    assign s_rresp      = {2{M_AXI_RRESP}};

    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = req_q.addr;
    assign M_AXI_ARID    = req_q.id;
    assign M_AXI_ARLEN   = req_q.len;
    assign M_AXI_ARSIZE  = req_q.size;
    assign M_AXI_ARBURST = req_q.burst;
    assign busy          = (state != ST_IDLE);
    assign proto_err     = proto_err_q;

    // Return routing is by grant alone, so the slave's RID carries no information here.
    assign unused_rid = ^M_AXI_RID;

    always_ff @(posedge clock) begin
        if (!rst_n_sync) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            beat_cnt    <= 9'd0;
            arvalid_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant_oh) begin
                        req_q     <= win_req;
                        grant     <= win;
                        arvalid_q <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        beat_cnt  <= 9'd0;
                        state     <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (M_AXI_RLAST) begin
                            // beat_cnt still excludes this beat, so a correct burst ends at ARLEN.
                            if (beat_cnt != {1'b0, req_q.len}) begin
                                proto_err_q <= 1'b1;
                            end
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
